// File: rtl/e_clk_phase_gen_pkg.sv
// Shared definitions for the 6809 E-clock phase generator: default sizing and
// the per-tap delay state encoding.
package e_clk_phase_gen_pkg;

    localparam int NUM_TAPS_DEF  = 4;
    localparam int DLY_W_DEF     = 8;
    localparam int STALL_CYC_DEF = 200;

    typedef enum logic {
        TAP_IDLE    = 1'b0,
        TAP_PENDING = 1'b1
    } tap_state_e;

endpackage

// File: rtl/e_clk_tap.sv
// One delayed copy of E: each edge pulse is replayed on o_tap after i_dly+1
// cycles, with a newer edge flushing any still-pending one.
//
// state       | meaning
// TAP_IDLE    | no edge in flight, o_tap holds the last applied level
// TAP_PENDING | edge captured, cnt_q counting down to the moment lvl_q is applied
module e_clk_tap
    import e_clk_phase_gen_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_edge,
    input  logic             i_level,
    input  logic [DLY_W-1:0] i_dly,
    output logic             o_tap
);

    tap_state_e       state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             tap_q, tap_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= TAP_IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            tap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            tap_q   <= tap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        tap_d   = tap_q;

        if (state_q == TAP_PENDING) begin
            if (cnt_q == '0) begin
                tap_d   = lvl_q;
                state_d = TAP_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (i_edge) begin
            // A new edge forces out the pending level now so no edge is lost.
            if (state_q == TAP_PENDING) begin
                tap_d = lvl_q;
            end
            if ((i_dly == '0) && (state_q == TAP_IDLE)) begin
                tap_d   = i_level;
                state_d = TAP_IDLE;
            end else begin
                lvl_d   = i_level;
                state_d = TAP_PENDING;
                cnt_d   = (i_dly == '0) ? '0 : i_dly - 1'b1;
            end
        end
    end

    assign o_tap = tap_q;

endmodule

// File: rtl/e_clk_phase_gen.sv
// 6809 E-clock phase generator: synchronises E, emits edge pulses, delayed taps
// and the E-high length. Optional stuck-E detector under E_CLK_STALL_DETECT_EN.
module e_clk_phase_gen
    import e_clk_phase_gen_pkg::*;
#(
    parameter int NUM_TAPS  = NUM_TAPS_DEF,
    parameter int DLY_W     = DLY_W_DEF,
    parameter int STALL_CYC = STALL_CYC_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_e_clk,
    input  logic [NUM_TAPS*DLY_W-1:0] i_tap_dly,
    output logic [NUM_TAPS-1:0]       o_e_tap,
    output logic                      o_e_rise,
    output logic                      o_e_fall,
    output logic [DLY_W-1:0]          o_e_high_cnt,
    output logic                      o_stall
);

    logic             e_meta, e_sync, e_hist;
    logic             rise_det, fall_det, edge_det;
    logic [DLY_W-1:0] high_cnt_q;

    assign rise_det = e_sync & ~e_hist;
    assign fall_det = ~e_sync & e_hist;
    assign edge_det = rise_det | fall_det;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            e_meta   <= 1'b0;
            e_sync   <= 1'b0;
            e_hist   <= 1'b0;
            o_e_rise <= 1'b0;
            o_e_fall <= 1'b0;
        end else begin
            e_meta   <= i_e_clk;
            e_sync   <= e_meta;
            e_hist   <= e_sync;
            o_e_rise <= rise_det;
            o_e_fall <= fall_det;
        end
    end

    // Restarts at 1 on the rise so the first high cycle is counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            high_cnt_q   <= '0;
            o_e_high_cnt <= '0;
        end else begin
            if (rise_det) begin
                high_cnt_q <= DLY_W'(1);
            end else if (e_sync && (high_cnt_q != '1)) begin
                high_cnt_q <= high_cnt_q + 1'b1;
            end
            if (fall_det) begin
                o_e_high_cnt <= high_cnt_q;
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        e_clk_tap #(
            .DLY_W (DLY_W)
        ) u_tap (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_edge  (o_e_rise | o_e_fall),
            .i_level (o_e_rise),
            .i_dly   (i_tap_dly[k*DLY_W +: DLY_W]),
            .o_tap   (o_e_tap[k])
        );
    end

`ifdef E_CLK_STALL_DETECT_EN
    localparam int                HOLD_W   = $clog2(STALL_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STALL_CYC);

    logic [HOLD_W-1:0] hold_q;
    logic              stall_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q  <= '0;
            stall_q <= 1'b0;
        end else if (edge_det) begin
            hold_q  <= HOLD_W'(1);
            stall_q <= 1'b0;
        end else begin
            if (hold_q != HOLD_MAX) begin
                hold_q <= hold_q + 1'b1;
            end
            if (hold_q >= HOLD_MAX - 1'b1) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign o_stall = stall_q;
`else
    assign o_stall = 1'b0;
`endif

endmodule
